// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver with mid-bit sampling and one-cycle dv/err strobes.
// Define UART_RX_PARITY_EN to add one even-parity bit between the data bits and the stop bit.
module uart_rx #(
    parameter int CLKS_PER_BIT = 217
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_rx_serial,
    output logic       o_rx_dv,
    output logic [7:0] o_rx_byte,
    output logic       o_rx_err
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] CNT_HALF = CW'((CLKS_PER_BIT - 1) / 2);

`ifdef UART_RX_PARITY_EN
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;
`else
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        STOP   = 3'd4
    } state_t;
`endif

    state_t          state;
    state_t          state_next;

    logic            rx_meta;
    logic            rx_sync;
    logic            rx_s;

    logic [CW-1:0]   cnt;
    logic [2:0]      bit_idx;
    logic [7:0]      rx_shift;

    logic            bit_tick;
    logic            cnt_clr;
    logic            cnt_inc;
    logic            idx_clr;
    logic            sample_data;
    logic            stop_good;
    logic            frame_ok;
    logic            frame_bad;

`ifdef UART_RX_PARITY_EN
    logic            parity_err;
    logic            sample_par;
`endif

    // Two-flop synchronizer plus one registered stage that the FSM samples
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= i_rx_serial;
            rx_sync <= rx_meta;
            rx_s    <= rx_sync;
        end
    end

    assign bit_tick = (cnt == CNT_LAST);

`ifdef UART_RX_PARITY_EN
    assign stop_good = rx_s && !parity_err;
`else
    assign stop_good = rx_s;
`endif

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // A start bit that is no longer low at its midpoint is treated as a glitch
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (!rx_s) begin
                    state_next = START;
                end
            end
            START: begin
                if (cnt == CNT_HALF) begin
                    state_next = rx_s ? IDLE : DATA;
                end
            end
            DATA: begin
                if (bit_tick && (bit_idx == 3'd7)) begin
`ifdef UART_RX_PARITY_EN
                    state_next = PARITY;
`else
                    state_next = STOP;
`endif
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (bit_tick) begin
                    state_next = STOP;
                end
            end
`endif
            STOP: begin
                if (bit_tick) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_comb begin
        cnt_clr     = 1'b0;
        cnt_inc     = 1'b0;
        idx_clr     = 1'b0;
        sample_data = 1'b0;
        frame_ok    = 1'b0;
        frame_bad   = 1'b0;
`ifdef UART_RX_PARITY_EN
        sample_par  = 1'b0;
`endif
        case (state)
            IDLE: begin
                cnt_clr = 1'b1;
                idx_clr = 1'b1;
            end
            START: begin
                if (cnt == CNT_HALF) begin
                    cnt_clr = 1'b1;
                end else begin
                    cnt_inc = 1'b1;
                end
            end
            DATA: begin
                if (bit_tick) begin
                    cnt_clr     = 1'b1;
                    sample_data = 1'b1;
                end else begin
                    cnt_inc = 1'b1;
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (bit_tick) begin
                    cnt_clr    = 1'b1;
                    sample_par = 1'b1;
                end else begin
                    cnt_inc = 1'b1;
                end
            end
`endif
            STOP: begin
                if (bit_tick) begin
                    cnt_clr   = 1'b1;
                    frame_ok  = stop_good;
                    frame_bad = !stop_good;
                end else begin
                    cnt_inc = 1'b1;
                end
            end
            default: begin
                cnt_clr = 1'b1;
                idx_clr = 1'b1;
            end
        endcase
    end

    // Datapath: bit timer, bit index, shift register and registered strobes
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt       <= '0;
            bit_idx   <= 3'd0;
            rx_shift  <= 8'h00;
            o_rx_byte <= 8'h00;
            o_rx_dv   <= 1'b0;
            o_rx_err  <= 1'b0;
        end else begin
            o_rx_dv  <= frame_ok;
            o_rx_err <= frame_bad;

            if (cnt_clr) begin
                cnt <= '0;
            end else if (cnt_inc) begin
                cnt <= cnt + CW'(1);
            end

            if (idx_clr) begin
                bit_idx <= 3'd0;
            end else if (sample_data) begin
                bit_idx <= bit_idx + 3'd1;
            end

            if (sample_data) begin
                rx_shift[bit_idx] <= rx_s;
            end

            if (frame_ok) begin
                o_rx_byte <= rx_shift;
            end
        end
    end

`ifdef UART_RX_PARITY_EN
    // Even parity: the data bits and the parity bit together must XOR to zero
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            parity_err <= 1'b0;
        end else if (idx_clr) begin
            parity_err <= 1'b0;
        end else if (sample_par) begin
            parity_err <= rx_s ^ (^rx_shift);
        end
    end
`endif

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed self-checking bench for uart_rx at 217 clocks per bit.
// Honours UART_RX_PARITY_EN the same way the design does.
module tb_uart_rx;

    localparam int CPB = 217;
`ifdef UART_RX_PARITY_EN
    localparam int LAT   = 2282;
    localparam int FRAME = 11 * CPB;
`else
    localparam int LAT   = 2065;
    localparam int FRAME = 10 * CPB;
`endif

    logic       clk;
    logic       rst_n;
    logic       rx_serial;
    logic       rx_dv;
    logic [7:0] rx_byte;
    logic       rx_err;

    int checks;
    int errors;
    int cyc;

    int dv_count;
    int err_count;
    int both_count;
    int dv_cyc_log [64];
    logic [7:0] dv_byte_log [64];
    int err_cyc_log [64];

    uart_rx #(.CLKS_PER_BIT(CPB)) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_rx_serial (rx_serial),
        .o_rx_dv     (rx_dv),
        .o_rx_byte   (rx_byte),
        .o_rx_err    (rx_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Strobe monitor: logs each high cycle with the edge number it follows
    initial begin
        dv_count   = 0;
        err_count  = 0;
        both_count = 0;
    end
    always @(negedge clk) begin
        if (rx_dv && dv_count < 64) begin
            dv_cyc_log[dv_count]  = cyc;
            dv_byte_log[dv_count] = rx_byte;
        end
        if (rx_err && err_count < 64) begin
            err_cyc_log[err_count] = cyc;
        end
        if (rx_dv) dv_count = dv_count + 1;
        if (rx_err) err_count = err_count + 1;
        if (rx_dv && rx_err) both_count = both_count + 1;
    end

    task automatic drive_bit(input logic v);
        rx_serial = v;
        repeat (CPB) @(negedge clk);
    endtask

    // Called at a negedge; returns the edge number that captures the start bit
    task automatic send_frame(input logic [7:0] data, input logic stop_val,
                              input logic par_flip, output int start_edge);
        start_edge = cyc + 1;
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(data[i]);
`ifdef UART_RX_PARITY_EN
        drive_bit((^data) ^ par_flip);
`else
        if (par_flip) rx_serial = 1'b1;
`endif
        drive_bit(stop_val);
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        rx_serial = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            checks++;
            if (rx_dv !== 1'b0 || rx_err !== 1'b0 || rx_byte !== 8'h00) begin
                errors++;
                $display("[TB] FAIL reset_hold cycle %0d: dv=%b err=%b byte=%h, want 0 0 00",
                         i, rx_dv, rx_err, rx_byte);
            end
            rx_serial = 1'($urandom_range(0, 1));
        end
        rx_serial = 1'b1;
        repeat (5) @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        checks++;
        if (dv_count !== 0 || err_count !== 0) begin
            errors++;
            $display("[TB] FAIL reset_release: dv_count=%0d err_count=%0d, want 0 0",
                     dv_count, err_count);
        end
    endtask

    task automatic test_single_frame;
        int s;
        int dv0;
        int er0;
        dv0 = dv_count;
        er0 = err_count;
        send_frame(8'h42, 1'b1, 1'b0, s);
        repeat (300) @(negedge clk);
        checks++;
        if (dv_count - dv0 !== 1) begin
            errors++;
            $display("[TB] FAIL single_count: got %0d pulses, want 1", dv_count - dv0);
        end
        checks++;
        if (dv_cyc_log[dv0] !== s + LAT) begin
            errors++;
            $display("[TB] FAIL single_latency: strobe after edge %0d, want %0d",
                     dv_cyc_log[dv0] - s, LAT);
        end
        checks++;
        if (dv_byte_log[dv0] !== 8'h42 || rx_byte !== 8'h42) begin
            errors++;
            $display("[TB] FAIL single_byte: strobe byte %h held %h, want 42",
                     dv_byte_log[dv0], rx_byte);
        end
        checks++;
        if (err_count !== er0) begin
            errors++;
            $display("[TB] FAIL single_err: got %0d err pulses, want 0", err_count - er0);
        end
    endtask

    task automatic test_back_to_back;
        int s1;
        int s2;
        int dv0;
        dv0 = dv_count;
        send_frame(8'hA5, 1'b1, 1'b0, s1);
        send_frame(8'h3C, 1'b1, 1'b0, s2);
        repeat (300) @(negedge clk);
        checks++;
        if (dv_count - dv0 !== 2) begin
            errors++;
            $display("[TB] FAIL b2b_count: got %0d pulses, want 2", dv_count - dv0);
        end
        checks++;
        if (dv_cyc_log[dv0 + 1] - dv_cyc_log[dv0] !== FRAME) begin
            errors++;
            $display("[TB] FAIL b2b_spacing: got %0d cycles, want %0d",
                     dv_cyc_log[dv0 + 1] - dv_cyc_log[dv0], FRAME);
        end
        checks++;
        if (dv_byte_log[dv0] !== 8'hA5 || dv_byte_log[dv0 + 1] !== 8'h3C) begin
            errors++;
            $display("[TB] FAIL b2b_bytes: got %h %h, want a5 3c",
                     dv_byte_log[dv0], dv_byte_log[dv0 + 1]);
        end
    endtask

    task automatic test_start_glitch;
        int s;
        int dv0;
        int er0;
        dv0 = dv_count;
        er0 = err_count;
        rx_serial = 1'b0;
        repeat (50) @(negedge clk);
        rx_serial = 1'b1;
        repeat (300) @(negedge clk);
        checks++;
        if (dv_count !== dv0 || err_count !== er0) begin
            errors++;
            $display("[TB] FAIL glitch_silent: dv +%0d err +%0d, want 0 0",
                     dv_count - dv0, err_count - er0);
        end
        send_frame(8'h81, 1'b1, 1'b0, s);
        repeat (300) @(negedge clk);
        checks++;
        if (dv_count - dv0 !== 1 || dv_byte_log[dv0] !== 8'h81 || dv_cyc_log[dv0] !== s + LAT) begin
            errors++;
            $display("[TB] FAIL glitch_next_frame: pulses %0d byte %h at +%0d, want 1 81 at +%0d",
                     dv_count - dv0, dv_byte_log[dv0], dv_cyc_log[dv0] - s, LAT);
        end
    endtask

    task automatic test_framing_error;
        int s;
        int dv0;
        int er0;
        int waited;
        dv0 = dv_count;
        er0 = err_count;
        send_frame(8'hFF, 1'b0, 1'b0, s);
        waited = 0;
        while (err_count - er0 < 2 && waited < 3000) begin
            @(negedge clk);
            waited++;
        end
        rx_serial = 1'b1;
        checks++;
        if (err_count - er0 < 2) begin
            errors++;
            $display("[TB] FAIL ferr_timeout: got %0d err pulses, want 2 while line low",
                     err_count - er0);
        end
        checks++;
        if (err_cyc_log[er0] !== s + LAT) begin
            errors++;
            $display("[TB] FAIL ferr_latency: err after edge %0d, want %0d",
                     err_cyc_log[er0] - s, LAT);
        end
        checks++;
        if (err_cyc_log[er0 + 1] - err_cyc_log[er0] !== LAT - 2) begin
            errors++;
            $display("[TB] FAIL ferr_retrigger: second err %0d cycles later, want %0d",
                     err_cyc_log[er0 + 1] - err_cyc_log[er0], LAT - 2);
        end
        repeat (400) @(negedge clk);
        checks++;
        if (rx_byte !== 8'h81 || dv_count !== dv0 || err_count - er0 !== 2) begin
            errors++;
            $display("[TB] FAIL ferr_hold: byte %h dv +%0d err +%0d, want 81 0 2",
                     rx_byte, dv_count - dv0, err_count - er0);
        end
    endtask

    task automatic test_reset_mid_frame;
        int s;
        int dv0;
        int er0;
        rx_serial = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 4; i++) drive_bit(1'b1);
        rx_serial = 1'b1;
        repeat (CPB / 2) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        checks++;
        if (rx_dv !== 1'b0 || rx_err !== 1'b0 || rx_byte !== 8'h00) begin
            errors++;
            $display("[TB] FAIL midreset_outputs: dv=%b err=%b byte=%h, want 0 0 00",
                     rx_dv, rx_err, rx_byte);
        end
        repeat (4) @(negedge clk);
        rst_n = 1'b1;
        repeat (CPB) @(negedge clk);
        dv0 = dv_count;
        er0 = err_count;
        send_frame(8'h5A, 1'b1, 1'b0, s);
        repeat (300) @(negedge clk);
        checks++;
        if (dv_count - dv0 !== 1 || dv_byte_log[dv0] !== 8'h5A || rx_byte !== 8'h5A) begin
            errors++;
            $display("[TB] FAIL midreset_frame: pulses %0d byte %h, want 1 5a",
                     dv_count - dv0, rx_byte);
        end
        checks++;
        if (err_count !== er0 || dv_cyc_log[dv0] !== s + LAT) begin
            errors++;
            $display("[TB] FAIL midreset_clean: err +%0d latency %0d, want 0 %0d",
                     err_count - er0, dv_cyc_log[dv0] - s, LAT);
        end
    endtask

`ifdef UART_RX_PARITY_EN
    task automatic test_parity;
        int s;
        int dv0;
        int er0;
        dv0 = dv_count;
        er0 = err_count;
        send_frame(8'h5A, 1'b1, 1'b1, s);
        repeat (300) @(negedge clk);
        checks++;
        if (err_count - er0 !== 1 || dv_count !== dv0 || rx_byte !== 8'h5A) begin
            errors++;
            $display("[TB] FAIL parity_bad: err +%0d dv +%0d, want 1 0",
                     err_count - er0, dv_count - dv0);
        end
        send_frame(8'h3B, 1'b1, 1'b0, s);
        repeat (300) @(negedge clk);
        checks++;
        if (dv_count - dv0 !== 1 || rx_byte !== 8'h3B || dv_cyc_log[dv0] !== s + 2282) begin
            errors++;
            $display("[TB] FAIL parity_good: pulses %0d byte %h latency %0d, want 1 3b 2282",
                     dv_count - dv0, rx_byte, dv_cyc_log[dv0] - s);
        end
    endtask
`endif

    initial begin
        checks = 0;
        errors = 0;
        rst_n = 1'b0;
        rx_serial = 1'b1;
        @(negedge clk);
        test_reset;
        test_single_frame;
        test_back_to_back;
        test_start_glitch;
        test_framing_error;
        test_reset_mid_frame;
`ifdef UART_RX_PARITY_EN
        test_parity;
`endif
        checks++;
        if (both_count !== 0) begin
            errors++;
            $display("[TB] FAIL dv_err_overlap: %0d cycles with both high, want 0", both_count);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
# uart_rx

Serial-to-parallel UART receiver for the 25 MHz board clock: 8 data bits, LSB first, 1 start bit, 1 stop bit, no flow control. It samples each bit at mid-bit and presents each completed byte with a one-cycle valid strobe. It is the receive end of the host link and feeds the byte register that drives the two seven-segment digit decoders (high nibble to digit 1, low nibble to digit 2).

## Interface
- CLKS_PER_BIT, default 217, i_clk cycles per bit (25 MHz / 115200 baud); legal range 8..65535.
- i_clk  in  1  system clock; all logic on the rising edge.
- i_rst_n  in  1  reset; one clock; reset is asynchronous and active-low.
- i_rx_serial  in  1  asynchronous serial line, idle high.
- o_rx_dv  out  1  one-cycle strobe: o_rx_byte was updated this cycle.
- o_rx_byte  out  8  last good byte; holds until the next good frame.
- o_rx_err  out  1  one-cycle strobe: frame rejected (framing/parity error).

## Operation
- i_rx_serial passes through a two-flop synchronizer; both flops reset to 1. The FSM sees only the synchronized value, rx_s.
- Bit counter: $clog2(CLKS_PER_BIT) bits. Bit index: 3 bits. H = (CLKS_PER_BIT-1)/2, integer division.
- IDLE: counter and index cleared. rx_s==0 → START.
- START: counter increments each cycle. When counter==H: if rx_s==0 → DATA, counter cleared; else → IDLE (glitch; no strobe).
- DATA: when counter==CLKS_PER_BIT-1: shift rx_s into bit[index], counter cleared, index+1. After index 7 → STOP (PARITY when enabled). Index wraps 7→0.
- STOP: when counter==CLKS_PER_BIT-1, sample rx_s:
  - rx_s==1 and no parity error: o_rx_byte ← shift register, o_rx_dv=1.
  - Otherwise: o_rx_err=1 and o_rx_byte unchanged.
  - Both cases → IDLE.
- A stop bit sampled low leaves rx_s low in IDLE, so the receiver immediately retriggers START (break line). This is required behaviour.
- Reset asserted mid-frame: immediate return to IDLE, outputs at their reset values, partial byte discarded.
- o_rx_dv and o_rx_err are never high in the same cycle.

## Timing
- Reset values: o_rx_dv=0, o_rx_err=0, o_rx_byte=8'h00, state IDLE.
- Latency, with edge 0 as the first i_clk edge that captures the low start bit:
  - START is entered at edge 3.
  - DATA is entered at edge 4+H.
  - Data bit n is sampled at edge 4+H+(n+1)·CLKS_PER_BIT.
  - The stop bit is sampled at edge 4+H+9·CLKS_PER_BIT.
  - o_rx_dv/o_rx_err are high for exactly the cycle following that edge.
  - With defaults, the strobe follows edge 2065.
- Back-to-back frames (next start bit immediately after the stop bit) are received with no loss.
- No backpressure: the consumer must take the byte on the o_rx_dv cycle or read the held o_rx_byte later.

## Configuration
- UART_RX_PARITY_EN defined:
  - A PARITY state follows DATA and samples one even-parity bit after CLKS_PER_BIT cycles.
  - A mismatch makes the frame fail at STOP (o_rx_err, byte not updated).
  - Strobe latency increases by CLKS_PER_BIT cycles.
- Undefined: no PARITY state; the frame is 10 bits and timing is as above.

## Test plan
- Reset: hold i_rst_n=0 with i_rx_serial toggling → o_rx_dv=0, o_rx_err=0, o_rx_byte=8'h00 throughout.
- Single frame 8'h42 at 217 clocks/bit → one o_rx_dv pulse after edge 2065; o_rx_byte=8'h42 and held afterwards; o_rx_err stays 0.
- Back-to-back 8'hA5, 8'h3C → exactly two o_rx_dv pulses 2170 cycles apart, with bytes A5 then 3C.
- Start glitch: line low for 50 cycles then high → no strobe, FSM returns to IDLE; a following 8'h81 frame is received correctly.
- Framing error: frame 8'hFF with stop bit low → one o_rx_err pulse, o_rx_byte keeps its previous value, START retriggers while the line stays low.
- Reset at data bit 4, then a clean frame 8'h5A → only 8'h5A is reported. With UART_RX_PARITY_EN: 8'h5A with wrong parity → o_rx_err; correct parity → o_rx_dv after edge 2282.
